qpsk_symbol_packer: RTL and testbench

Downstream stage of the QPSK demodulator NoC block: consumes the symbol-rate, bit-synchronised `{I,Q}` samples it produces and hard-decides each symbol into a 2-bit dibit. It packs 16 dibits MSB-first into 32-bit words and emits them as AXI-stream packets of a configurable word count. Output is buffered so host back-pressure does not stall the free-running demodulator. An optional differential decoder removes the Costas loop's 90° phase ambiguity.

---
 rtl/qpsk_pkg.sv | 23 ++
 rtl/qpsk_pack_fifo.sv | 63 ++++++
 rtl/qpsk_symbol_packer.sv | 143 ++++++++++++++
 tb/tb_qpsk_symbol_packer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// Shared constants and the hard-decision helper for the QPSK symbol packer.
package qpsk_pkg;
  localparam int SYMS_PER_WORD = 16;
  localparam int DIBIT_W       = 2;
  localparam int WORD_W        = SYMS_PER_WORD * DIBIT_W;

  typedef logic [DIBIT_W-1:0] dibit_t;

  localparam dibit_t QUAD_0 = 2'd0;
  localparam dibit_t QUAD_1 = 2'd1;
  localparam dibit_t QUAD_2 = 2'd2;
  localparam dibit_t QUAD_3 = 2'd3;

  // Quadrant from the sign bits; zero counts as positive.
  function automatic dibit_t quadrant(input logic i_neg, input logic q_neg);
    case ({i_neg, q_neg})
      2'b00:   quadrant = QUAD_0;
      2'b10:   quadrant = QUAD_1;
      2'b11:   quadrant = QUAD_2;
      default: quadrant = QUAD_3;
    endcase
  endfunction
endpackage

// File: rtl/qpsk_pack_fifo.sv
// Flop-based synchronous FIFO for packed words (data + tlast); a push into a
// full FIFO succeeds when a pop frees the head slot in the same cycle.
module qpsk_pack_fifo #(
  parameter int AW = 4,
  parameter int DW = 33
) (
  input  logic          ce_clk,
  input  logic          ce_rst,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          wr_drop,
  input  logic          rd_en,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]              level_q, level_d;
  logic                     push, pop;

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == (AW+1)'(DEPTH));
    pop     = rd_en & ~empty;
    push    = wr_en & (~full | pop);
    wr_drop = wr_en & ~push;
    mem_d   = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // Storage needs no reset: the read port is forced to zero while empty.
  always_ff @(posedge ce_clk) mem_q <= mem_d;

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign level    = level_q;
endmodule

// File: rtl/qpsk_symbol_packer.sv
// Hard-decides QPSK symbols to dibits, packs 16 per 32-bit word MSB-first and
// frames them into AXI-stream packets. QPSK_DIFF_DECODE_EN enables differential decode.
module qpsk_symbol_packer
  import qpsk_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int PKT_W   = 16
) (
  input  logic               ce_clk,
  input  logic               ce_rst,
  input  logic               clear,
  input  logic [31:0]        sym_tdata,
  input  logic               sym_tvalid,
  input  logic               flush,
  input  logic [PKT_W-1:0]   pkt_words,
  output logic [31:0]        o_tdata,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               o_tready,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
);
  logic              dib_vld_q, dib_vld_d, flush_q, flush_d;
  dibit_t            dib_q, dib_d;
  logic [3:0]        sym_cnt_q, sym_cnt_d, sym_cnt_nx;
  logic [PKT_W-1:0]  word_cnt_q, word_cnt_d, pkt_lat_q, pkt_lat_d, lat_m1;
  logic [WORD_W-1:0] word_q, word_d, word_nx, push_data;
  logic              overflow_q, overflow_d;
  logic              push, push_last, wr_drop, complete;
  logic [4:0]        bit_idx;
  logic [32:0]       rd_data;
  logic              unused_bits;

  assign unused_bits = ^{sym_tdata[30:16], sym_tdata[14:0]};

`ifdef QPSK_DIFF_DECODE_EN
  dibit_t q_prev_q, q_prev_d, quad;

  always_comb begin
    quad     = quadrant(sym_tdata[31], sym_tdata[15]);
    dib_d    = quad - q_prev_q;  // 2-bit wrap gives the mod-4 difference
    q_prev_d = q_prev_q;
    if (sym_tvalid)     q_prev_d = quad;
    if (flush || clear) q_prev_d = '0;
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) q_prev_q <= '0;
    else        q_prev_q <= q_prev_d;
  end
`else
  assign dib_d = {sym_tdata[31], sym_tdata[15]};
`endif

  assign dib_vld_d = sym_tvalid & ~clear;
  assign flush_d   = flush & ~clear;

  always_comb begin
    bit_idx    = 5'd30 - {sym_cnt_q, 1'b0};
    word_nx    = word_q;
    if (dib_vld_q) word_nx[bit_idx +: DIBIT_W] = dib_q;
    sym_cnt_nx = sym_cnt_q + {3'b0, dib_vld_q};
    complete   = dib_vld_q & (sym_cnt_q == 4'd15);
    lat_m1     = (pkt_lat_q == '0) ? '0 : pkt_lat_q - PKT_W'(1);

    push      = 1'b0;
    push_last = 1'b0;
    push_data = word_nx;
    // A symbol arriving with flush is packed first; if it fills the word, that word carries tlast.
    if (complete) begin
      push      = 1'b1;
      push_last = (word_cnt_q == lat_m1) | flush_q;
    end else if (flush_q) begin
      if (sym_cnt_nx != 4'd0) begin
        push      = 1'b1;
        push_last = 1'b1;
      end else if (word_cnt_q != '0) begin
        push      = 1'b1;
        push_last = 1'b1;
        push_data = '0;
      end
    end

    // Dropped words leave word_cnt alone so later tlast positions stay put.
    word_cnt_d = word_cnt_q;
    if (flush_q)                word_cnt_d = '0;
    else if (push && !wr_drop)  word_cnt_d = push_last ? '0 : word_cnt_q + PKT_W'(1);

    sym_cnt_d  = flush_q ? 4'd0 : sym_cnt_nx;
    word_d     = (push || flush_q) ? '0 : word_nx;
    pkt_lat_d  = (word_cnt_q == '0 && sym_cnt_q == 4'd0) ? pkt_words : pkt_lat_q;
    overflow_d = overflow_q | wr_drop;

    if (clear) begin
      word_cnt_d = '0;
      sym_cnt_d  = '0;
      word_d     = '0;
      pkt_lat_d  = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      dib_vld_q  <= 1'b0;
      dib_q      <= '0;
      flush_q    <= 1'b0;
      sym_cnt_q  <= '0;
      word_cnt_q <= '0;
      pkt_lat_q  <= '0;
      word_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      dib_vld_q  <= dib_vld_d;
      dib_q      <= dib_d;
      flush_q    <= flush_d;
      sym_cnt_q  <= sym_cnt_d;
      word_cnt_q <= word_cnt_d;
      pkt_lat_q  <= pkt_lat_d;
      word_q     <= word_d;
      overflow_q <= overflow_d;
    end
  end

  qpsk_pack_fifo #(.AW(FIFO_AW), .DW(33)) u_fifo (
    .ce_clk   (ce_clk),
    .ce_rst   (ce_rst),
    .clear    (clear),
    .wr_en    (push),
    .wr_data  ({push_data, push_last}),
    .wr_drop  (wr_drop),
    .rd_en    (o_tready),
    .rd_valid (o_tvalid),
    .rd_data  (rd_data),
    .full     (),
    .empty    (),
    .level    (fifo_level)
  );

  assign o_tdata  = rd_data[32:1];
  assign o_tlast  = rd_data[0];
  assign overflow = overflow_q;
endmodule

// File: tb/tb_qpsk_symbol_packer.sv
// Bench for qpsk_symbol_packer: directed scenarios plus randomized traffic checked
// every cycle against a symbol-level packet model and an ideal output queue.
`timescale 1ns/1ps
module tb_qpsk_symbol_packer;
  localparam int AW = 2, PW = 16, DEPTH = 4;

  logic          ce_clk = 1'b0, ce_rst, clear, sym_tvalid, flush, o_tready;
  logic [31:0]   sym_tdata, o_tdata;
  logic [PW-1:0] pkt_words;
  logic          o_tlast, o_tvalid, overflow;
  logic [AW:0]   fifo_level;

  qpsk_symbol_packer #(.FIFO_AW(AW), .PKT_W(PW)) dut (
    .ce_clk(ce_clk), .ce_rst(ce_rst), .clear(clear), .sym_tdata(sym_tdata),
    .sym_tvalid(sym_tvalid), .flush(flush), .pkt_words(pkt_words), .o_tdata(o_tdata),
    .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 ce_clk = ~ce_clk;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [32:0] mq[$];           // ideal output FIFO contents {data, last}
  bit          movf, pend_v, pend_last, pend_fl, m_ok;
  logic [31:0] pend_data, m_word;
  int          m_sc, m_wc, m_lat, m_qprev, m_iv, m_qv, m_quad, m_dib;

  always @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst || clear) begin
      mq.delete(); movf = 0; pend_v = 0; m_sc = 0; m_wc = 0; m_lat = 1; m_qprev = 0; m_word = 0;
    end else begin
      if (mq.size() > 0 && o_tready) void'(mq.pop_front());
      if (pend_v) begin
        m_ok = mq.size() < DEPTH;
        if (m_ok) mq.push_back({pend_data, pend_last}); else movf = 1;
        if (pend_fl) m_wc = 0; else if (m_ok) m_wc = pend_last ? 0 : m_wc + 1;
      end
      pend_v = 0;
      if (m_sc == 0 && m_wc == 0) m_lat = (pkt_words == 0) ? 1 : int'(pkt_words);
      if (sym_tvalid) begin
        m_iv = int'($signed(sym_tdata[31:16]));
        m_qv = int'($signed(sym_tdata[15:0]));
        m_quad = (m_iv >= 0 && m_qv >= 0) ? 0 : (m_iv < 0 && m_qv >= 0) ? 1 :
                 (m_iv < 0 && m_qv < 0) ? 2 : 3;
`ifdef QPSK_DIFF_DECODE_EN
        m_dib = (m_quad - m_qprev + 4) % 4;
`else
        m_dib = (m_iv < 0 ? 2 : 0) + (m_qv < 0 ? 1 : 0);
`endif
        m_qprev = m_quad;
        m_word = m_word | (32'(m_dib) << (30 - 2 * m_sc));
        m_sc++;
      end
      if (m_sc == 16) begin
        pend_v = 1; pend_data = m_word; pend_last = (m_wc == m_lat - 1) || flush; pend_fl = flush;
        m_sc = 0; m_word = 0;
      end else if (flush) begin
        if (m_sc > 0) begin
          pend_v = 1; pend_data = m_word; pend_last = 1; pend_fl = 1;
        end else if (m_wc > 0) begin
          pend_v = 1; pend_data = 0; pend_last = 1; pend_fl = 1;
        end
        m_sc = 0; m_word = 0;
      end
      if (flush) m_qprev = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  int hs_cnt = 0, last_cnt = 0;
  always @(negedge ce_clk) begin
    chk("tvalid", o_tvalid, mq.size() > 0);
    chk("fifo_level", fifo_level, mq.size());
    chk("overflow", overflow, movf);
    if (mq.size() > 0) begin
      chk("tdata", o_tdata, mq[0][32:1]);
      chk("tlast", o_tlast, mq[0][0]);
    end
    if (o_tvalid && o_tready) begin
      hs_cnt++;
      if (o_tlast) last_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(); @(posedge ce_clk); #1; endtask
  task automatic idle(input int n); repeat (n) cyc(); endtask
  task automatic send(input logic [15:0] i, input logic [15:0] q);
    sym_tdata = {i, q}; sym_tvalid = 1; cyc(); sym_tvalid = 0;
  endtask
  task automatic pulse_flush(); flush = 1; cyc(); flush = 0; endtask
  task automatic pulse_clear(); clear = 1; cyc(); clear = 0; endtask
  task automatic quad_send(input int qd);
    case (qd)
      0: send(16'sd100, 16'sd100);
      1: send(-16'sd100, 16'sd100);
      2: send(-16'sd100, -16'sd100);
      default: send(16'sd100, -16'sd100);
    endcase
  endtask
  task automatic wait_valid(input string nm);
    int k = 0;
    while (!o_tvalid && k < 50) begin cyc(); k++; end
    chk(nm, o_tvalid, 1'b1);
  endtask
  function automatic logic [15:0] rcomp();
    case ($urandom_range(0, 3))
      0: rcomp = 16'h0000;
      1: rcomp = 16'hFFFF;
      default: rcomp = 16'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp1, exp3, exp5, exp6;
  initial begin
`ifdef QPSK_DIFF_DECODE_EN
    exp1 = 32'hC000_0000; exp3 = 32'h8000_0000; exp5 = 32'h1451_4514; exp6 = 32'hC000_0000;
`else
    exp1 = 32'h5555_5555; exp3 = 32'hFFC0_0000; exp5 = 32'h2F42_F42F; exp6 = 32'h5555_5555;
`endif
    ce_rst = 1; clear = 0; sym_tdata = 0; sym_tvalid = 0; flush = 0; o_tready = 0; pkt_words = 1;
    #2;
    chk("rst_tvalid", o_tvalid, 0); chk("rst_tlast", o_tlast, 0); chk("rst_tdata", o_tdata, 0);
    chk("rst_overflow", overflow, 0); chk("rst_level", fifo_level, 0);
    repeat (3) @(posedge ce_clk);
    #1 ce_rst = 0;
    idle(2);

    // Packing order and 2-cycle latency
    pkt_words = 1;
    repeat (16) send(16'sd100, -16'sd100);
    chk("t1_valid_early", o_tvalid, 0);
    cyc();
    chk("t1_valid", o_tvalid, 1); chk("t1_data", o_tdata, exp1); chk("t1_last", o_tlast, 1);
    o_tready = 1; idle(4);

    // Packet framing
    pkt_words = 3; idle(3); hs_cnt = 0; last_cnt = 0;
    repeat (48) send(16'($urandom), 16'($urandom));
    idle(6);
    chk("t2_words", hs_cnt, 3); chk("t2_lasts", last_cnt, 1);
    pkt_words = 0; idle(3); hs_cnt = 0; last_cnt = 0;
    repeat (32) send(16'($urandom), 16'($urandom));
    idle(6);
    chk("t2_words0", hs_cnt, 2); chk("t2_lasts0", last_cnt, 2);

    // Flush of a partial word, then idle flush
    pkt_words = 1; o_tready = 0; idle(2);
    repeat (5) send(-16'sd5, -16'sd5);
    pulse_flush();
    cyc();
    chk("t3_valid", o_tvalid, 1); chk("t3_data", o_tdata, exp3); chk("t3_last", o_tlast, 1);
    o_tready = 1; idle(3); hs_cnt = 0;
    pulse_flush(); idle(5);
    chk("t3_idle_flush", hs_cnt, 0);

    // Back-pressure and overflow
    pulse_clear(); pkt_words = 2; o_tready = 0; idle(2);
    repeat (80) send(16'($urandom), 16'($urandom));
    idle(4);
    chk("t4_level", fifo_level, 4); chk("t4_overflow", overflow, 1);
    hs_cnt = 0; last_cnt = 0; o_tready = 1; idle(8);
    chk("t4_words", hs_cnt, 4); chk("t4_lasts", last_cnt, 2);
    chk("t4_overflow_sticky", overflow, 1);
    pulse_clear();
    chk("t4_overflow_clr", overflow, 0);

    // Quadrant pattern (differential decode in the macro build)
    pkt_words = 1; o_tready = 0; idle(2);
    for (int k = 0; k < 16; k++) begin
      case (k % 6) 0: quad_send(0); 1: quad_send(1); 2: quad_send(2);
                   3: quad_send(2); 4: quad_send(3); default: quad_send(0); endcase
    end
    wait_valid("t5_valid");
    chk("t5_data", o_tdata, exp5); chk("t5_last", o_tlast, 1);
    o_tready = 1; idle(3);

    // Async reset mid-packet
    o_tready = 0; pkt_words = 2; idle(2);
    repeat (16) send(16'($urandom), 16'($urandom));
    repeat (7) send(16'($urandom), 16'($urandom));
    idle(1);
    chk("t6_queued", fifo_level, 1);
    #3 ce_rst = 1;
    #1;
    chk("t6_rst_valid", o_tvalid, 0); chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_tdata", o_tdata, 0); chk("t6_rst_tlast", o_tlast, 0);
    @(posedge ce_clk); #1 ce_rst = 0;
    repeat (16) send(16'sd100, -16'sd100);
    cyc();
    chk("t6_valid", o_tvalid, 1); chk("t6_data", o_tdata, exp6); chk("t6_last", o_tlast, 0);
    pulse_flush(); o_tready = 1; idle(6);

    // Randomized traffic
    for (int ph = 0; ph < 4; ph++) begin
      pulse_clear();
      pkt_words = PW'(ph);
      idle(2);
      for (int n = 0; n < 1500; n++) begin
        sym_tvalid = ($urandom_range(0, 3) != 0);
        sym_tdata  = {rcomp(), rcomp()};
        flush      = ($urandom_range(0, 40) == 0);
        o_tready   = ($urandom_range(0, 2) != 0);
        cyc();
      end
      sym_tvalid = 0; flush = 0; o_tready = 1;
      idle(10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
